// File: rtl/demortl_dma_arbiter.sv
// ---------------------------------------------------------------------------
// demortl_dma_arbiter
//
// Purpose:
//   Shares one ESP-style DMA port (read ctrl/chnl + write ctrl/chnl) among
//   NCLI accelerator clients. The read and write paths are arbitrated
//   independently and round-robin, one whole transaction at a time. A grant
//   is held until every data beat of the granted transaction has moved.
//
// Parameters:
//   NCLI           number of clients (2..4)
//   DMA_BUS_WIDTH  data beat width (DW)
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cli_rd_ctrl_*                    per-client read requests (packed)
//   cli_rd_chnl_*                    per-client read beats (data broadcast)
//   cli_wr_ctrl_*                    per-client write requests (packed)
//   cli_wr_chnl_*                    per-client write beats (packed data)
//   dma_read_ctrl_* / dma_read_chnl_*    shared DMA read port
//   dma_write_ctrl_* / dma_write_chnl_*  shared DMA write port
//   debug                            transaction statistics or 32'h0
//
// Optional feature:
//   DEMORTL_DMA_ARB_STATS_EN  when defined, debug = {rd_txn_cnt, wr_txn_cnt},
//   two 16-bit wrapping counters of completed transactions. When undefined,
//   debug is tied to zero and no counters exist.
// ---------------------------------------------------------------------------

// One arbitration channel: IDLE -> CTRL -> DATA -> IDLE. The top level owns
// all data muxing; this block only decides who is granted and when the
// transaction is over.
module demortl_dma_arb_chan #(
  parameter int NCLI = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_i,         // requests, zero-padded to 4 clients
  input  logic [31:0] sel_len_i,     // length of the granted client's request
  input  logic        ctrl_ready_i,  // DMA accepts the ctrl word
  input  logic        beat_fire_i,   // a data beat transfers this cycle
  output logic [1:0]  grant_o,
  output logic        ctrl_phase_o,
  output logic        data_phase_o,
  output logic        done_o         // transaction completes this cycle
);

  typedef enum logic [1:0] {S_IDLE, S_CTRL, S_DATA} state_t;

  state_t      state_q;
  logic [1:0]  grant_q;
  logic [1:0]  ptr_q;
  logic [31:0] cnt_q;
  logic [31:0] len_q;

  logic [1:0]  pick_d;
  logic        found_d;
  logic [1:0]  ptr_d;
  logic        last_beat_d;

  // First requester at or after the pointer. Rotating modulo 4 over the
  // zero-padded request vector yields the same order as rotating modulo
  // NCLI, because the padding slots never request.
  always_comb begin
    logic [1:0] cand;
    found_d = 1'b0;
    pick_d  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found_d && req_i[cand]) begin
        found_d = 1'b1;
        pick_d  = cand;
      end
    end
  end

  assign ptr_d       = (grant_q == 2'(NCLI - 1)) ? 2'd0 : grant_q + 2'd1;
  assign last_beat_d = (cnt_q == len_q - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 32'd0;
      len_q   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            grant_q <= pick_d;
            cnt_q   <= 32'd0;
            state_q <= S_CTRL;
          end
        end
        S_CTRL: begin
          if (ctrl_ready_i) begin
            ptr_q   <= ptr_d;
            // The client may change its fields after the handshake, so the
            // length that governs the data phase is captured here.
            len_q   <= sel_len_i;
            state_q <= (sel_len_i == 32'd0) ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (beat_fire_i) begin
            cnt_q <= cnt_q + 32'd1;
            if (last_beat_d) begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant_o      = grant_q;
  assign ctrl_phase_o = (state_q == S_CTRL);
  assign data_phase_o = (state_q == S_DATA);
  assign done_o       = (ctrl_phase_o && ctrl_ready_i && (sel_len_i == 32'd0)) ||
                        (data_phase_o && beat_fire_i && last_beat_d);

endmodule

module demortl_dma_arbiter #(
  parameter int NCLI          = 2,
  parameter int DMA_BUS_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  // client read side
  input  logic [NCLI-1:0]            cli_rd_ctrl_valid,
  output logic [NCLI-1:0]            cli_rd_ctrl_ready,
  input  logic [32*NCLI-1:0]         cli_rd_ctrl_index,
  input  logic [32*NCLI-1:0]         cli_rd_ctrl_length,
  input  logic [3*NCLI-1:0]          cli_rd_ctrl_size,
  output logic [NCLI-1:0]            cli_rd_chnl_valid,
  input  logic [NCLI-1:0]            cli_rd_chnl_ready,
  output logic [DMA_BUS_WIDTH-1:0]   cli_rd_chnl_data,
  // client write side
  input  logic [NCLI-1:0]            cli_wr_ctrl_valid,
  output logic [NCLI-1:0]            cli_wr_ctrl_ready,
  input  logic [32*NCLI-1:0]         cli_wr_ctrl_index,
  input  logic [32*NCLI-1:0]         cli_wr_ctrl_length,
  input  logic [3*NCLI-1:0]          cli_wr_ctrl_size,
  input  logic [NCLI-1:0]            cli_wr_chnl_valid,
  output logic [NCLI-1:0]            cli_wr_chnl_ready,
  input  logic [DMA_BUS_WIDTH*NCLI-1:0] cli_wr_chnl_data,
  // shared DMA read port
  output logic                       dma_read_ctrl_valid,
  input  logic                       dma_read_ctrl_ready,
  output logic [31:0]                dma_read_ctrl_data_index,
  output logic [31:0]                dma_read_ctrl_data_length,
  output logic [2:0]                 dma_read_ctrl_data_size,
  input  logic                       dma_read_chnl_valid,
  output logic                       dma_read_chnl_ready,
  input  logic [DMA_BUS_WIDTH-1:0]   dma_read_chnl_data,
  // shared DMA write port
  output logic                       dma_write_ctrl_valid,
  input  logic                       dma_write_ctrl_ready,
  output logic [31:0]                dma_write_ctrl_data_index,
  output logic [31:0]                dma_write_ctrl_data_length,
  output logic [2:0]                 dma_write_ctrl_data_size,
  output logic                       dma_write_chnl_valid,
  input  logic                       dma_write_chnl_ready,
  output logic [DMA_BUS_WIDTH-1:0]   dma_write_chnl_data,
  output logic [31:0]                debug
);

  localparam int DW = DMA_BUS_WIDTH;

  // Per-client fields unpacked into 4-entry tables so a 2-bit grant can index
  // them for any NCLI; unused entries read as zero.
  logic [3:0]    rd_req4, wr_req4;
  logic [3:0]    rd_cli_rdy4, wr_cli_vld4;
  logic [31:0]   rd_idx_a  [4];
  logic [31:0]   rd_len_a  [4];
  logic [2:0]    rd_size_a [4];
  logic [31:0]   wr_idx_a  [4];
  logic [31:0]   wr_len_a  [4];
  logic [2:0]    wr_size_a [4];
  logic [DW-1:0] wr_data_a [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_tab
      if (gi < NCLI) begin : g_used
        assign rd_req4[gi]     = cli_rd_ctrl_valid[gi];
        assign wr_req4[gi]     = cli_wr_ctrl_valid[gi];
        assign rd_cli_rdy4[gi] = cli_rd_chnl_ready[gi];
        assign wr_cli_vld4[gi] = cli_wr_chnl_valid[gi];
        assign rd_idx_a[gi]    = cli_rd_ctrl_index[32*gi +: 32];
        assign rd_len_a[gi]    = cli_rd_ctrl_length[32*gi +: 32];
        assign rd_size_a[gi]   = cli_rd_ctrl_size[3*gi +: 3];
        assign wr_idx_a[gi]    = cli_wr_ctrl_index[32*gi +: 32];
        assign wr_len_a[gi]    = cli_wr_ctrl_length[32*gi +: 32];
        assign wr_size_a[gi]   = cli_wr_ctrl_size[3*gi +: 3];
        assign wr_data_a[gi]   = cli_wr_chnl_data[DW*gi +: DW];
      end else begin : g_pad
        assign rd_req4[gi]     = 1'b0;
        assign wr_req4[gi]     = 1'b0;
        assign rd_cli_rdy4[gi] = 1'b0;
        assign wr_cli_vld4[gi] = 1'b0;
        assign rd_idx_a[gi]    = 32'd0;
        assign rd_len_a[gi]    = 32'd0;
        assign rd_size_a[gi]   = 3'd0;
        assign wr_idx_a[gi]    = 32'd0;
        assign wr_len_a[gi]    = 32'd0;
        assign wr_size_a[gi]   = 3'd0;
        assign wr_data_a[gi]   = '0;
      end
    end
  endgenerate

  // ---------------- read path ----------------
  logic [1:0] rd_g;
  logic       rd_ctrl, rd_data, rd_fire, rd_done;

  assign rd_fire = rd_data && dma_read_chnl_valid && rd_cli_rdy4[rd_g];

  demortl_dma_arb_chan #(.NCLI(NCLI)) u_rd (
    .clk          (clk),
    .rst          (rst),
    .req_i        (rd_req4),
    .sel_len_i    (rd_len_a[rd_g]),
    .ctrl_ready_i (dma_read_ctrl_ready),
    .beat_fire_i  (rd_fire),
    .grant_o      (rd_g),
    .ctrl_phase_o (rd_ctrl),
    .data_phase_o (rd_data),
    .done_o       (rd_done)
  );

  assign dma_read_ctrl_valid       = rd_ctrl;
  assign dma_read_ctrl_data_index  = rd_ctrl ? rd_idx_a[rd_g]  : 32'd0;
  assign dma_read_ctrl_data_length = rd_ctrl ? rd_len_a[rd_g]  : 32'd0;
  assign dma_read_ctrl_data_size   = rd_ctrl ? rd_size_a[rd_g] : 3'd0;
  assign dma_read_chnl_ready       = rd_data && rd_cli_rdy4[rd_g];
  assign cli_rd_chnl_data          = rd_data ? dma_read_chnl_data : '0;

  // ---------------- write path ----------------
  logic [1:0] wr_g;
  logic       wr_ctrl, wr_data, wr_fire, wr_done;

  assign wr_fire = wr_data && wr_cli_vld4[wr_g] && dma_write_chnl_ready;

  demortl_dma_arb_chan #(.NCLI(NCLI)) u_wr (
    .clk          (clk),
    .rst          (rst),
    .req_i        (wr_req4),
    .sel_len_i    (wr_len_a[wr_g]),
    .ctrl_ready_i (dma_write_ctrl_ready),
    .beat_fire_i  (wr_fire),
    .grant_o      (wr_g),
    .ctrl_phase_o (wr_ctrl),
    .data_phase_o (wr_data),
    .done_o       (wr_done)
  );

  assign dma_write_ctrl_valid       = wr_ctrl;
  assign dma_write_ctrl_data_index  = wr_ctrl ? wr_idx_a[wr_g]  : 32'd0;
  assign dma_write_ctrl_data_length = wr_ctrl ? wr_len_a[wr_g]  : 32'd0;
  assign dma_write_ctrl_data_size   = wr_ctrl ? wr_size_a[wr_g] : 3'd0;
  assign dma_write_chnl_valid       = wr_data && wr_cli_vld4[wr_g];
  assign dma_write_chnl_data        = wr_data ? wr_data_a[wr_g] : '0;

  // Per-client handshake steering: only the granted client sees the DMA side.
  generate
    for (genvar gi = 0; gi < NCLI; gi++) begin : g_steer
      assign cli_rd_ctrl_ready[gi] = rd_ctrl && (rd_g == 2'(gi)) && dma_read_ctrl_ready;
      assign cli_rd_chnl_valid[gi] = rd_data && (rd_g == 2'(gi)) && dma_read_chnl_valid;
      assign cli_wr_ctrl_ready[gi] = wr_ctrl && (wr_g == 2'(gi)) && dma_write_ctrl_ready;
      assign cli_wr_chnl_ready[gi] = wr_data && (wr_g == 2'(gi)) && dma_write_chnl_ready;
    end
  endgenerate

  // ---------------- statistics ----------------
`ifdef DEMORTL_DMA_ARB_STATS_EN
  logic [15:0] rd_txn_cnt_q, wr_txn_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_txn_cnt_q <= 16'd0;
      wr_txn_cnt_q <= 16'd0;
    end else begin
      if (rd_done) rd_txn_cnt_q <= rd_txn_cnt_q + 16'd1;
      if (wr_done) wr_txn_cnt_q <= wr_txn_cnt_q + 16'd1;
    end
  end

  assign debug = {rd_txn_cnt_q, wr_txn_cnt_q};
`else
  logic unused_done;
  assign unused_done = rd_done | wr_done;
  assign debug       = 32'h0;
`endif

endmodule

// File: tb/tb_demortl_dma_arbiter.sv
// Randomized scoreboard bench for demortl_dma_arbiter. Stimulus is issued in
// rounds of simultaneous requests; the reference model orders each round by
// round-robin arithmetic and queues the expected ctrl words and beats. An
// independent monitor pops and compares whenever a DMA handshake happens.
module tb_demortl_dma_arbiter;

  localparam int NCLI = 2;
  localparam int DW   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NCLI-1:0]      cli_rd_ctrl_valid, cli_rd_ctrl_ready;
  logic [32*NCLI-1:0]   cli_rd_ctrl_index, cli_rd_ctrl_length;
  logic [3*NCLI-1:0]    cli_rd_ctrl_size;
  logic [NCLI-1:0]      cli_rd_chnl_valid, cli_rd_chnl_ready;
  logic [DW-1:0]        cli_rd_chnl_data;
  logic [NCLI-1:0]      cli_wr_ctrl_valid, cli_wr_ctrl_ready;
  logic [32*NCLI-1:0]   cli_wr_ctrl_index, cli_wr_ctrl_length;
  logic [3*NCLI-1:0]    cli_wr_ctrl_size;
  logic [NCLI-1:0]      cli_wr_chnl_valid, cli_wr_chnl_ready;
  logic [DW*NCLI-1:0]   cli_wr_chnl_data;
  logic                 dma_read_ctrl_valid, dma_read_ctrl_ready;
  logic [31:0]          dma_read_ctrl_data_index, dma_read_ctrl_data_length;
  logic [2:0]           dma_read_ctrl_data_size;
  logic                 dma_read_chnl_valid, dma_read_chnl_ready;
  logic [DW-1:0]        dma_read_chnl_data;
  logic                 dma_write_ctrl_valid, dma_write_ctrl_ready;
  logic [31:0]          dma_write_ctrl_data_index, dma_write_ctrl_data_length;
  logic [2:0]           dma_write_ctrl_data_size;
  logic                 dma_write_chnl_valid, dma_write_chnl_ready;
  logic [DW-1:0]        dma_write_chnl_data;
  logic [31:0]          debug;

  demortl_dma_arbiter #(.NCLI(NCLI), .DMA_BUS_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .cli_rd_ctrl_valid(cli_rd_ctrl_valid), .cli_rd_ctrl_ready(cli_rd_ctrl_ready),
    .cli_rd_ctrl_index(cli_rd_ctrl_index), .cli_rd_ctrl_length(cli_rd_ctrl_length),
    .cli_rd_ctrl_size(cli_rd_ctrl_size),
    .cli_rd_chnl_valid(cli_rd_chnl_valid), .cli_rd_chnl_ready(cli_rd_chnl_ready),
    .cli_rd_chnl_data(cli_rd_chnl_data),
    .cli_wr_ctrl_valid(cli_wr_ctrl_valid), .cli_wr_ctrl_ready(cli_wr_ctrl_ready),
    .cli_wr_ctrl_index(cli_wr_ctrl_index), .cli_wr_ctrl_length(cli_wr_ctrl_length),
    .cli_wr_ctrl_size(cli_wr_ctrl_size),
    .cli_wr_chnl_valid(cli_wr_chnl_valid), .cli_wr_chnl_ready(cli_wr_chnl_ready),
    .cli_wr_chnl_data(cli_wr_chnl_data),
    .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
    .dma_read_ctrl_data_index(dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
    .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
    .dma_read_chnl_data(dma_read_chnl_data),
    .dma_write_ctrl_valid(dma_write_ctrl_valid), .dma_write_ctrl_ready(dma_write_ctrl_ready),
    .dma_write_ctrl_data_index(dma_write_ctrl_data_index),
    .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
    .dma_write_ctrl_data_size(dma_write_ctrl_data_size),
    .dma_write_chnl_valid(dma_write_chnl_valid), .dma_write_chnl_ready(dma_write_chnl_ready),
    .dma_write_chnl_data(dma_write_chnl_data),
    .debug(debug)
  );

  typedef struct packed {
    logic [1:0]  c;
    logic [31:0] idx;
    logic [31:0] len;
    logic [2:0]  size;
  } ctrl_t;

  typedef struct packed {
    logic [1:0]    c;
    logic [DW-1:0] data;
  } wbeat_t;

  ctrl_t      rd_ctrl_q[$];
  ctrl_t      wr_ctrl_q[$];
  logic [1:0] rd_beat_q[$];
  wbeat_t     wr_beat_q[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;
  bit force_rdy = 1'b0;

  // reference model state
  int rd_ptr = 0, wr_ptr = 0;
  int rd_txns = 0, wr_txns = 0;

  // environment state
  logic [31:0] wr_idx_f [NCLI];
  logic [31:0] wr_len_f [NCLI];
  int          wr_left  [NCLI];
  int          wr_beat  [NCLI];
  int          rd_left;

  function automatic logic [DW-1:0] payload(int c, logic [31:0] idx, int b);
    return {8'(c), idx[23:0], 32'(b)};
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- environment: clients and DMA engine ----------------
  initial begin
    bit          rdc_fire, rdb_fire;
    logic [31:0] rdc_len;
    bit          rdc_hs [NCLI];
    bit          wrc_hs [NCLI];
    bit          wrb_fire [NCLI];
    cli_rd_ctrl_valid = '0; cli_rd_ctrl_index = '0; cli_rd_ctrl_length = '0;
    cli_rd_ctrl_size = '0; cli_rd_chnl_ready = '0;
    cli_wr_ctrl_valid = '0; cli_wr_ctrl_index = '0; cli_wr_ctrl_length = '0;
    cli_wr_ctrl_size = '0; cli_wr_chnl_valid = '0; cli_wr_chnl_data = '0;
    dma_read_ctrl_ready = 1'b0; dma_read_chnl_valid = 1'b0; dma_read_chnl_data = '0;
    dma_write_ctrl_ready = 1'b0; dma_write_chnl_ready = 1'b0;
    rd_left = 0;
    for (int c = 0; c < NCLI; c++) begin
      wr_left[c] = 0; wr_beat[c] = 0; wr_idx_f[c] = '0; wr_len_f[c] = '0;
    end
    forever begin
      @(negedge clk);
      rdc_fire = dma_read_ctrl_valid && dma_read_ctrl_ready;
      rdc_len  = dma_read_ctrl_data_length;
      rdb_fire = dma_read_chnl_valid && dma_read_chnl_ready;
      for (int c = 0; c < NCLI; c++) begin
        rdc_hs[c]   = cli_rd_ctrl_valid[c] && cli_rd_ctrl_ready[c];
        wrc_hs[c]   = cli_wr_ctrl_valid[c] && cli_wr_ctrl_ready[c];
        wrb_fire[c] = cli_wr_chnl_valid[c] && cli_wr_chnl_ready[c];
      end
      @(posedge clk);
      #1;
      if (rst) begin
        cli_rd_ctrl_valid = '0; cli_wr_ctrl_valid = '0; cli_wr_chnl_valid = '0;
        dma_read_chnl_valid = 1'b0; rd_left = 0;
        for (int c = 0; c < NCLI; c++) begin
          wr_left[c] = 0; wr_beat[c] = 0;
        end
        continue;
      end
      for (int c = 0; c < NCLI; c++) begin
        if (rdc_hs[c]) cli_rd_ctrl_valid[c] = 1'b0;
        if (wrc_hs[c]) begin
          cli_wr_ctrl_valid[c] = 1'b0;
          wr_left[c] = int'(wr_len_f[c]);
          wr_beat[c] = 0;
        end
        if (wrb_fire[c]) begin
          wr_beat[c]++;
          wr_left[c]--;
          cli_wr_chnl_valid[c] = 1'b0;
        end
        if (!cli_wr_chnl_valid[c] && wr_left[c] > 0)
          cli_wr_chnl_valid[c] = force_rdy || ($urandom_range(0, 3) != 0);
        cli_wr_chnl_data[DW*c +: DW] = payload(c, wr_idx_f[c], wr_beat[c]);
        cli_rd_chnl_ready[c] = force_rdy || ($urandom_range(0, 2) != 0);
      end
      dma_read_ctrl_ready  = force_rdy || ($urandom_range(0, 1) != 0);
      dma_write_ctrl_ready = force_rdy || ($urandom_range(0, 1) != 0);
      dma_write_chnl_ready = force_rdy || ($urandom_range(0, 1) != 0);
      if (rdc_fire) rd_left = (rdc_len > 64) ? 64 : int'(rdc_len);
      if (rdb_fire) begin
        rd_left--;
        dma_read_chnl_valid = 1'b0;
      end
      if (!dma_read_chnl_valid && rd_left > 0) begin
        dma_read_chnl_valid = force_rdy || ($urandom_range(0, 3) != 0);
        dma_read_chnl_data  = {$urandom, $urandom};
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    ctrl_t  ec;
    wbeat_t ew;
    logic [1:0] eb;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
          if (rd_ctrl_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_ctrl_unexpected: got idx %h expected no request", dma_read_ctrl_data_index);
          end else begin
            ec = rd_ctrl_q.pop_front();
            $display("rd ctrl: client %0d idx %h len %0d", ec.c, ec.idx, ec.len);
            chk("rd_ctrl_grant", DW'(cli_rd_ctrl_ready), DW'(1 << ec.c));
            chk("rd_ctrl_index", DW'(dma_read_ctrl_data_index), DW'(ec.idx));
            chk("rd_ctrl_length", DW'(dma_read_ctrl_data_length), DW'(ec.len));
            chk("rd_ctrl_size", DW'(dma_read_ctrl_data_size), DW'(ec.size));
          end
        end
        if (dma_read_chnl_valid && dma_read_chnl_ready) begin
          if (rd_beat_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_beat_unexpected: got valid %b expected no beat", cli_rd_chnl_valid);
          end else begin
            eb = rd_beat_q.pop_front();
            chk("rd_beat_route", DW'(cli_rd_chnl_valid), DW'(1 << eb));
            chk("rd_beat_data", cli_rd_chnl_data, dma_read_chnl_data);
          end
        end else if (cli_rd_chnl_valid != '0 && !(rd_beat_q.size() > 0 &&
                     cli_rd_chnl_valid == NCLI'(1 << rd_beat_q[0]))) begin
          checks++; errors++;
          $display("FAIL rd_stray_valid: got %b expected none", cli_rd_chnl_valid);
        end
        if (dma_write_ctrl_valid && dma_write_ctrl_ready) begin
          if (wr_ctrl_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_ctrl_unexpected: got idx %h expected no request", dma_write_ctrl_data_index);
          end else begin
            ec = wr_ctrl_q.pop_front();
            $display("wr ctrl: client %0d idx %h len %0d", ec.c, ec.idx, ec.len);
            chk("wr_ctrl_grant", DW'(cli_wr_ctrl_ready), DW'(1 << ec.c));
            chk("wr_ctrl_index", DW'(dma_write_ctrl_data_index), DW'(ec.idx));
            chk("wr_ctrl_length", DW'(dma_write_ctrl_data_length), DW'(ec.len));
            chk("wr_ctrl_size", DW'(dma_write_ctrl_data_size), DW'(ec.size));
          end
        end
        if (dma_write_chnl_valid && dma_write_chnl_ready) begin
          if (wr_beat_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_beat_unexpected: got data %h expected no beat", dma_write_chnl_data);
          end else begin
            ew = wr_beat_q.pop_front();
            chk("wr_beat_route", DW'(cli_wr_chnl_ready), DW'(1 << ew.c));
            chk("wr_beat_data", dma_write_chnl_data, ew.data);
          end
        end
      end
    end
  end

  // ---------------- reference model: one round of simultaneous requests ----
  task automatic issue_round(logic [NCLI-1:0] rd_set, logic [NCLI-1:0] wr_set);
    ctrl_t e;
    wbeat_t w;
    int last;
    @(posedge clk);
    #2;
    last = -1;
    for (int k = 0; k < NCLI; k++) begin
      int c = (rd_ptr + k) % NCLI;
      if (rd_set[c]) begin
        e.c = 2'(c); e.idx = $urandom; e.len = $urandom_range(0, 6); e.size = 3'($urandom);
        cli_rd_ctrl_index[32*c +: 32]  = e.idx;
        cli_rd_ctrl_length[32*c +: 32] = e.len;
        cli_rd_ctrl_size[3*c +: 3]     = e.size;
        cli_rd_ctrl_valid[c]           = 1'b1;
        rd_ctrl_q.push_back(e);
        for (int b = 0; b < int'(e.len); b++) rd_beat_q.push_back(2'(c));
        rd_txns++;
        last = c;
      end
    end
    if (last >= 0) rd_ptr = (last + 1) % NCLI;
    last = -1;
    for (int k = 0; k < NCLI; k++) begin
      int c = (wr_ptr + k) % NCLI;
      if (wr_set[c]) begin
        e.c = 2'(c); e.idx = $urandom; e.len = $urandom_range(0, 6); e.size = 3'($urandom);
        wr_idx_f[c] = e.idx;
        wr_len_f[c] = e.len;
        cli_wr_ctrl_index[32*c +: 32]  = e.idx;
        cli_wr_ctrl_length[32*c +: 32] = e.len;
        cli_wr_ctrl_size[3*c +: 3]     = e.size;
        cli_wr_ctrl_valid[c]           = 1'b1;
        wr_ctrl_q.push_back(e);
        for (int b = 0; b < int'(e.len); b++) begin
          w.c = 2'(c); w.data = payload(c, e.idx, b);
          wr_beat_q.push_back(w);
        end
        wr_txns++;
        last = c;
      end
    end
    if (last >= 0) wr_ptr = (last + 1) % NCLI;
  endtask

  task automatic wait_drain(string name);
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      done = (rd_ctrl_q.size() == 0) && (wr_ctrl_q.size() == 0) &&
             (rd_beat_q.size() == 0) && (wr_beat_q.size() == 0);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d/%0d rd and %0d/%0d wr items left expected 0",
               name, rd_ctrl_q.size(), rd_beat_q.size(), wr_ctrl_q.size(), wr_beat_q.size());
      rd_ctrl_q.delete(); wr_ctrl_q.delete(); rd_beat_q.delete(); wr_beat_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_stats(string name);
`ifdef DEMORTL_DMA_ARB_STATS_EN
    chk(name, DW'(debug), DW'({16'(rd_txns), 16'(wr_txns)}));
`else
    chk(name, DW'(debug), DW'(32'h0));
`endif
  endtask

  task automatic check_outputs_zero(string tag);
    chk({tag, "_cli_rd"}, DW'({cli_rd_ctrl_ready, cli_rd_chnl_valid}), '0);
    chk({tag, "_cli_rd_data"}, cli_rd_chnl_data, '0);
    chk({tag, "_cli_wr"}, DW'({cli_wr_ctrl_ready, cli_wr_chnl_ready}), '0);
    chk({tag, "_dma_rd_hs"}, DW'({dma_read_ctrl_valid, dma_read_chnl_ready}), '0);
    chk({tag, "_dma_rd_ctrl"}, DW'({dma_read_ctrl_data_index, dma_read_ctrl_data_length[28:0],
                                   dma_read_ctrl_data_size}), '0);
    chk({tag, "_dma_wr_hs"}, DW'({dma_write_ctrl_valid, dma_write_chnl_valid}), '0);
    chk({tag, "_dma_wr_ctrl"}, DW'({dma_write_ctrl_data_index, dma_write_ctrl_data_length[28:0],
                                   dma_write_ctrl_data_size}), '0);
    chk({tag, "_dma_wr_data"}, dma_write_chnl_data, '0);
    chk({tag, "_len_hi"}, DW'({dma_read_ctrl_data_length[31:29], dma_write_ctrl_data_length[31:29]}), '0);
    check_stats({tag, "_debug"});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int nb;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #2 rst = 1'b0;

    // fixed opening rounds: contention from pointer 0, then a lone requester
    issue_round(2'b11, 2'b00);
    wait_drain("contend_rd");
    issue_round(2'b11, 2'b11);
    wait_drain("contend_both");
    issue_round(2'b10, 2'b10);
    wait_drain("single");
    check_stats("stats_fixed");

    for (int r = 0; r < 40; r++) begin
      logic [NCLI-1:0] rs, ws;
      rs = NCLI'($urandom);
      ws = NCLI'($urandom);
      if (rs == '0 && ws == '0) rs[0] = 1'b1;
      issue_round(rs, ws);
      wait_drain("round");
      check_stats("stats_round");
    end

    // reset in the middle of a long read: outputs drop, arbiter restarts clean
    mon_en    = 1'b0;
    force_rdy = 1'b1;
    @(posedge clk);
    #2;
    cli_rd_ctrl_index[31:0]  = 32'h200;
    cli_rd_ctrl_length[31:0] = 32'd8;
    cli_rd_ctrl_size[2:0]    = 3'd3;
    cli_rd_ctrl_valid[0]     = 1'b1;
    nb = 0;
    for (int i = 0; i < 200 && nb < 1; i++) begin
      @(negedge clk);
      if (dma_read_chnl_valid && dma_read_chnl_ready) nb++;
    end
    chk("midrst_first_beat_route", DW'(cli_rd_chnl_valid), DW'(1));
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_txns = 0; wr_txns = 0; rd_ptr = 0; wr_ptr = 0;
    check_outputs_zero("midrst");
    @(posedge clk);
    #2 rst = 1'b0;
    rd_ctrl_q.delete(); wr_ctrl_q.delete(); rd_beat_q.delete(); wr_beat_q.delete();
    mon_en = 1'b1;
    issue_round(2'b10, 2'b01);
    wait_drain("post_reset");
    check_stats("stats_post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
